series_adder_axi_responder: RTL and testbench

Responder end of the bit-serial series-adder stream. It accepts one header word, then 32 bit-plane beats (LSB plane first). Each plane carries bit k of M operands in data_i[M-1:0]. The block accumulates the sum of the M 32-bit operands serially and returns a 40-bit result as two 32-bit result packets with first/last flags. It sits behind the streamer/testbench driver as the compute core of the series-adder AXI path.

---
 rtl/series_adder_axi_responder.sv | 197 +++++++++++++++++++
 tb/tb_series_adder_axi_responder.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/series_adder_axi_responder.sv
// -----------------------------------------------------------------------------
// series_adder_axi_responder
//
// Responder/compute core of the bit-serial series-adder stream. A frame is one
// header beat (opcode in data_i[7:0]) followed by 32 bit-plane beats, LSB
// plane first. Plane k carries bit k of each of the M operands in
// data_i[M-1:0]. The block sums the operands serially into a 40-bit
// accumulator. It then returns the result as two 32-bit packets:
//   - low packet  : acc[31:0],          result_first = 1
//   - high packet : {24'b0, acc[39:32]}, result_last = 1
//
// Ports
//   clk           in   system clock, rising edge
//   rst_p         in   asynchronous active-high reset
//   module_idle   out  high while the FSM is in IDLE
//   data_rdy      out  input ready (beat accepted on data_vld && data_rdy)
//   data_vld      in   input beat valid
//   data_i[31:0]  in   header word or bit-plane (only low M bits of a plane used)
//   result_o[31:0]out  result packet payload
//   result_first  out  marks the low-word packet
//   result_last   out  marks the high-word packet
//   result_vld    out  result packet valid
//   result_rdy    in   downstream ready (packet consumed on vld && rdy)
//
// Parameters
//   M           operands per frame. The plane is data_i[M-1:0], so 1 <= M <= 32.
//   OPCODE_SUM  header opcode that opens a frame
//   TIMEOUT     consecutive idle cycles in RECV before a frame is abandoned
//               (only with SERIES_RESP_TIMEOUT_EN)
//
// Build option
//   SERIES_RESP_TIMEOUT_EN  when defined, RECV counts consecutive holes and
//                           abandons the frame after TIMEOUT of them, without
//                           sending any result. When undefined, RECV waits
//                           for the remaining planes indefinitely.
// -----------------------------------------------------------------------------
module series_adder_axi_responder #(
  parameter int         M          = 8,
  parameter logic [7:0] OPCODE_SUM = 8'h04,
  parameter int         TIMEOUT    = 64
) (
  input  logic        clk,
  input  logic        rst_p,
  output logic        module_idle,
  output logic        data_rdy,
  input  logic        data_vld,
  input  logic [31:0] data_i,
  output logic [31:0] result_o,
  output logic        result_first,
  output logic        result_last,
  output logic        result_vld,
  input  logic        result_rdy
);

  localparam int ACC_W = 40;
  localparam int PC_W  = $clog2(M + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RECV,
    S_SEND_LO,
    S_SEND_HI
  } state_t;

  // Number of set bits in one bit-plane: how many operands have bit k set.
  function automatic logic [PC_W-1:0] popcount(input logic [M-1:0] v);
    logic [PC_W-1:0] c;
    c = '0;
    for (int i = 0; i < M; i++) begin
      c = c + PC_W'(v[i]);
    end
    return c;
  endfunction

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [4:0]       plane_idx;

  logic             beat_acc;
  logic             is_header;
  logic             last_plane;
  logic [PC_W-1:0]  plane_cnt;
  logic [ACC_W-1:0] plane_term;
  logic [ACC_W-1:0] acc_sum;

  // Bits of data_i above the plane width (and above the opcode byte) carry
  // nothing for this block; fold them into a sink so every input bit has a
  // reader.
  logic             unused_data_bits;
  assign unused_data_bits = ^data_i;

  assign beat_acc   = data_vld && data_rdy;
  assign is_header  = (data_i[7:0] == OPCODE_SUM);
  assign last_plane = (plane_idx == 5'd31);

  // Plane k contributes popcount * 2^k. acc_sum already includes the beat
  // being accepted, so the low result word can be registered on the same
  // edge that takes plane 31.
  assign plane_cnt  = popcount(data_i[M-1:0]);
  assign plane_term = {{(ACC_W-PC_W){1'b0}}, plane_cnt} << plane_idx;
  assign acc_sum    = acc + plane_term;

`ifdef SERIES_RESP_TIMEOUT_EN
  localparam int HC_W = $clog2(TIMEOUT + 1);
  logic [HC_W-1:0] hole_cnt;
`endif

  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      state        <= S_IDLE;
      acc          <= '0;
      plane_idx    <= '0;
      data_rdy     <= 1'b1;
      module_idle  <= 1'b1;
      result_vld   <= 1'b0;
      result_o     <= '0;
      result_first <= 1'b0;
      result_last  <= 1'b0;
`ifdef SERIES_RESP_TIMEOUT_EN
      hole_cnt     <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          // Non-header beats are accepted and dropped.
          if (beat_acc && is_header) begin
            acc         <= '0;
            plane_idx   <= '0;
            module_idle <= 1'b0;
            state       <= S_RECV;
`ifdef SERIES_RESP_TIMEOUT_EN
            hole_cnt    <= '0;
`endif
          end
        end

        S_RECV: begin
          // data_rdy stays high here because the driver ignores backpressure.
          // A header-valued beat is just another plane.
          if (beat_acc) begin
            acc       <= acc_sum;
            plane_idx <= plane_idx + 5'd1;
`ifdef SERIES_RESP_TIMEOUT_EN
            hole_cnt  <= '0;
`endif
            if (last_plane) begin
              state        <= S_SEND_LO;
              data_rdy     <= 1'b0;
              result_vld   <= 1'b1;
              result_first <= 1'b1;
              result_last  <= 1'b0;
              result_o     <= acc_sum[31:0];
            end
          end
`ifdef SERIES_RESP_TIMEOUT_EN
          else if (hole_cnt == HC_W'(TIMEOUT - 1)) begin
            // This is the TIMEOUT-th consecutive hole. Abandon the frame.
            state       <= S_IDLE;
            acc         <= '0;
            plane_idx   <= '0;
            hole_cnt    <= '0;
            module_idle <= 1'b1;
          end else begin
            hole_cnt <= hole_cnt + HC_W'(1);
          end
`endif
        end

        S_SEND_LO: begin
          // Outputs hold until the low word is taken.
          if (result_rdy) begin
            state        <= S_SEND_HI;
            result_o     <= {24'b0, acc[39:32]};
            result_first <= 1'b0;
            result_last  <= 1'b1;
          end
        end

        S_SEND_HI: begin
          // result_o keeps the high word after the handshake.
          if (result_rdy) begin
            state       <= S_IDLE;
            result_vld  <= 1'b0;
            result_last <= 1'b0;
            data_rdy    <= 1'b1;
            module_idle <= 1'b1;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_series_adder_axi_responder.sv
module tb_series_adder_axi_responder;

  localparam int         M       = 8;
  localparam logic [7:0] OPCODE  = 8'h04;
  localparam int         TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst_p;
  logic        module_idle;
  logic        data_rdy;
  logic        data_vld;
  logic [31:0] data_i;
  logic [31:0] result_o;
  logic        result_first;
  logic        result_last;
  logic        result_vld;
  logic        result_rdy;

  always #5 clk = ~clk;

  series_adder_axi_responder #(
    .M(M),
    .OPCODE_SUM(OPCODE),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst_p(rst_p),
    .module_idle(module_idle),
    .data_rdy(data_rdy),
    .data_vld(data_vld),
    .data_i(data_i),
    .result_o(result_o),
    .result_first(result_first),
    .result_last(result_last),
    .result_vld(result_vld),
    .result_rdy(result_rdy)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int lo_cyc;
  int hi_cyc;
  int last_plane_cyc;

  // Scoreboard entry: {first, last, payload}
  logic [33:0] sb [$];
  logic [33:0] exp_pkt;
  logic [31:0] ops [M];

  always @(posedge clk) cyc <= cyc + 1;

  // Packet monitor: every consumed packet is popped and compared.
  always @(negedge clk) begin
    if (result_vld && result_rdy) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_packet actual=%h first=%0b last=%0b required=none",
                 result_o, result_first, result_last);
      end else begin
        exp_pkt = sb.pop_front();
        if ({result_first, result_last, result_o} !== exp_pkt) begin
          failures++;
          $display("FAIL packet actual={f=%0b l=%0b %h} required={f=%0b l=%0b %h}",
                   result_first, result_last, result_o, exp_pkt[33], exp_pkt[32], exp_pkt[31:0]);
        end
        if (exp_pkt[33]) lo_cyc = cyc;
        if (exp_pkt[32]) hi_cyc = cyc;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic v, input logic [31:0] d);
    data_vld = v;
    data_i   = d;
    @(posedge clk);
    #1;
  endtask

  task automatic push_expected();
    logic [39:0] s;
    s = '0;
    for (int j = 0; j < M; j++) s = s + {8'b0, ops[j]};
    sb.push_back({1'b1, 1'b0, s[31:0]});
    sb.push_back({1'b0, 1'b1, 24'b0, s[39:32]});
  endtask

  function automatic logic [31:0] plane_of(input int k);
    logic [31:0] p;
    p = $urandom;
    for (int j = 0; j < M; j++) p[j] = ops[j][k];
    return p;
  endfunction

  task automatic send_header();
    logic [31:0] h;
    h = $urandom;
    h[7:0] = OPCODE;
    drive(1'b1, h);
  endtask

  // Full frame; gap_len holes before plane gap_at, up to rand_holes holes before each plane.
  task automatic send_frame(input int rand_holes, input int gap_at, input int gap_len);
    push_expected();
    send_header();
    for (int k = 0; k < 32; k++) begin
      if (k == gap_at) repeat (gap_len) drive(1'b0, $urandom);
      if (rand_holes > 0) repeat ($urandom_range(0, rand_holes)) drive(1'b0, $urandom);
      drive(1'b1, plane_of(k));
    end
    last_plane_cyc = cyc;
    data_vld = 1'b0;
  endtask

  task automatic wait_drain(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (module_idle && !result_vld && sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    checks++; if (module_idle !== 1'b1) begin failures++; $display("FAIL reset_idle actual=%b required=1", module_idle); end
    checks++; if (data_rdy !== 1'b1) begin failures++; $display("FAIL reset_data_rdy actual=%b required=1", data_rdy); end
    checks++; if (result_vld !== 1'b0) begin failures++; $display("FAIL reset_vld actual=%b required=0", result_vld); end
    checks++; if (result_o !== 32'h0) begin failures++; $display("FAIL reset_result actual=%h required=0", result_o); end
    checks++; if ({result_first, result_last} !== 2'b00) begin failures++; $display("FAIL reset_flags actual=%b required=00", {result_first, result_last}); end
  endtask

  task automatic test_single_plane();
    bit ok;
    for (int j = 0; j < M; j++) ops[j] = 32'h1;
    lo_cyc = -1; hi_cyc = -1;
    result_rdy = 1'b1;
    send_frame(0, -1, 0);
    wait_drain(ok);
    checks++; if (!ok) begin failures++; $display("FAIL single_drain actual=pending required=drained"); end
    checks++; if (lo_cyc !== last_plane_cyc) begin failures++; $display("FAIL single_lo_latency actual=%0d required=%0d", lo_cyc, last_plane_cyc); end
    checks++; if (hi_cyc !== lo_cyc + 1) begin failures++; $display("FAIL single_hi_follows actual=%0d required=%0d", hi_cyc, lo_cyc + 1); end
    checks++; if (module_idle !== 1'b1) begin failures++; $display("FAIL single_idle_after actual=%b required=1", module_idle); end
  endtask

  task automatic test_all_ones();
    bit ok;
    for (int j = 0; j < M; j++) ops[j] = 32'hFFFF_FFFF;
    send_frame(0, -1, 0);
    wait_drain(ok);
    checks++; if (!ok) begin failures++; $display("FAIL all_ones_drain actual=pending required=drained"); end
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [31:0] h;
    for (int j = 0; j < M; j++) ops[j] = 32'(j + 1);
    result_rdy = 1'b0;
    send_frame(0, -1, 0);
    for (int i = 0; i < 5; i++) begin
      checks++; if (result_vld !== 1'b1) begin failures++; $display("FAIL bp_vld cycle=%0d actual=%b required=1", i, result_vld); end
      checks++; if ({result_first, result_last, result_o} !== {2'b10, 32'h24}) begin
        failures++; $display("FAIL bp_hold cycle=%0d actual={%b %b %h} required={1 0 00000024}", i, result_first, result_last, result_o);
      end
      checks++; if (data_rdy !== 1'b0) begin failures++; $display("FAIL bp_data_rdy cycle=%0d actual=%b required=0", i, data_rdy); end
      h = $urandom; h[7:0] = OPCODE;
      drive(1'b1, h);
    end
    data_vld = 1'b0;
    result_rdy = 1'b1;
    wait_drain(ok);
    checks++; if (!ok) begin failures++; $display("FAIL bp_drain actual=pending required=drained"); end
  endtask

  task automatic test_bad_header();
    bit ok;
    drive(1'b1, 32'h0000_0005);
    data_vld = 1'b0;
    checks++; if (module_idle !== 1'b1) begin failures++; $display("FAIL bad_header_idle actual=%b required=1", module_idle); end
    for (int j = 0; j < M; j++) ops[j] = 32'h0;
    ops[0] = 32'h2;
    send_frame(0, -1, 0);
    wait_drain(ok);
    checks++; if (!ok) begin failures++; $display("FAIL bad_header_drain actual=pending required=drained"); end
  endtask

  task automatic test_header_in_recv();
    bit ok;
    for (int j = 0; j < M; j++) ops[j] = 32'h0;
    ops[2] = 32'hFFFF_FFFF;
    send_frame(0, -1, 0);
    wait_drain(ok);
    checks++; if (!ok) begin failures++; $display("FAIL header_in_recv_drain actual=pending required=drained"); end
  endtask

  task automatic test_async_reset();
    bit ok;
    for (int j = 0; j < M; j++) ops[j] = $urandom;
    send_header();
    for (int k = 0; k < 10; k++) drive(1'b1, plane_of(k));
    data_vld = 1'b0;
    #2;
    rst_p = 1'b1;
    #1;
    checks++; if (module_idle !== 1'b1) begin failures++; $display("FAIL arst_idle actual=%b required=1", module_idle); end
    checks++; if (data_rdy !== 1'b1) begin failures++; $display("FAIL arst_data_rdy actual=%b required=1", data_rdy); end
    checks++; if ({result_vld, result_first, result_last} !== 3'b000) begin failures++; $display("FAIL arst_flags actual=%b required=000", {result_vld, result_first, result_last}); end
    @(posedge clk);
    #1;
    rst_p = 1'b0;
    for (int j = 0; j < M; j++) ops[j] = $urandom;
    send_frame(2, -1, 0);
    wait_drain(ok);
    checks++; if (!ok) begin failures++; $display("FAIL arst_next_frame actual=pending required=drained"); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    for (int f = 0; f < 4; f++) begin
      for (int j = 0; j < M; j++) ops[j] = $urandom;
      send_frame(f % 3, -1, 0);
      wait_drain(ok);
      checks++; if (!ok) begin failures++; $display("FAIL b2b_frame%0d actual=pending required=drained", f); end
    end
  endtask

`ifdef SERIES_RESP_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    for (int j = 0; j < M; j++) ops[j] = $urandom;
    send_header();
    for (int k = 0; k < 10; k++) drive(1'b1, plane_of(k));
    repeat (TIMEOUT) drive(1'b0, $urandom);
    checks++; if (module_idle !== 1'b1) begin failures++; $display("FAIL timeout_idle actual=%b required=1", module_idle); end
    checks++; if (result_vld !== 1'b0) begin failures++; $display("FAIL timeout_no_packet actual=%b required=0", result_vld); end
    for (int j = 0; j < M; j++) ops[j] = $urandom;
    send_frame(0, 10, TIMEOUT - 1);
    wait_drain(ok);
    checks++; if (!ok) begin failures++; $display("FAIL timeout_near_limit actual=pending required=drained"); end
  endtask
`else
  task automatic test_long_gap();
    bit ok;
    for (int j = 0; j < M; j++) ops[j] = $urandom;
    send_frame(0, 10, 100);
    wait_drain(ok);
    checks++; if (!ok) begin failures++; $display("FAIL long_gap actual=pending required=drained"); end
  endtask
`endif

  initial begin
    rst_p      = 1'b1;
    data_vld   = 1'b0;
    data_i     = '0;
    result_rdy = 1'b1;
    lo_cyc     = -1;
    hi_cyc     = -1;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst_p = 1'b0;
    @(posedge clk);
    #1;
    test_single_plane();
    test_all_ones();
    test_backpressure();
    test_bad_header();
    test_header_in_recv();
    test_async_reset();
    test_back_to_back();
`ifdef SERIES_RESP_TIMEOUT_EN
    test_timeout();
`else
    test_long_gap();
`endif
    repeat (3) @(posedge clk);
    #1;
    checks++; if (sb.size() != 0) begin failures++; $display("FAIL scoreboard_empty actual=%0d required=0", sb.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
